ahb_qos_arbiter: RTL and testbench

Registered, QoS-aware master arbiter for the shared AHB slave bus in the interconnect. It picks one of `NUM_MASTERS` requesters (CPU, CIM, Network, DMA) each bus turn by 2-bit static priority. Round-robin resolves ties, and per-master aging counters prevent starvation. The grant is held through incomplete transfers and bursts, and the winner index drives the interconnect's address/data routing mux.

---
 rtl/ahb_arb_pkg.sv | 27 ++
 rtl/ahb_rr_pick.sv | 28 ++
 rtl/ahb_qos_arbiter.sv | 125 ++++++++++++
 tb/tb_ahb_qos_arbiter.sv | 160 ++++++++++++++++
 4 files changed

// File: rtl/ahb_arb_pkg.sv
// Shared constants for the AHB QoS master arbiter: HTRANS codes, priority
// classes and the arbiter state encoding.
package ahb_arb_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic [1:0] PRIO_CPU = 2'd3;
  localparam logic [1:0] PRIO_CIM = 2'd2;
  localparam logic [1:0] PRIO_NET = 2'd1;
  localparam logic [1:0] PRIO_DMA = 2'd0;

  localparam logic [0:0] ARB_IDLE  = 1'b0;
  localparam logic [0:0] ARB_OWNED = 1'b1;

  // BUSY and SEQ keep the bus with the current burst owner.
  function automatic logic htrans_allows_ap(input logic [1:0] htrans);
    case (htrans)
      HTRANS_IDLE, HTRANS_NONSEQ: return 1'b1;
      HTRANS_BUSY, HTRANS_SEQ:    return 1'b0;
      default:                    return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/ahb_rr_pick.sv
// Combinational round-robin picker: first set bit of mask_i at or after
// start_i, wrapping modulo N.
module ahb_rr_pick #(
  parameter int unsigned N     = 4,
  parameter int unsigned IDX_W = $clog2(N)
) (
  input  logic [N-1:0]     mask_i,
  input  logic [IDX_W-1:0] start_i,
  output logic [IDX_W-1:0] idx_o,
  output logic             found_o
);

  always_comb begin
    int unsigned pos;
    pos     = 0;
    idx_o   = start_i;
    found_o = 1'b0;
    for (int unsigned off = 0; off < N; off++) begin
      pos = 32'(start_i) + off;
      if (pos >= N) pos = pos - N;
      if (!found_o && mask_i[pos[IDX_W-1:0]]) begin
        idx_o   = pos[IDX_W-1:0];
        found_o = 1'b1;
      end
    end
  end

endmodule

// File: rtl/ahb_qos_arbiter.sv
// Registered QoS master arbiter for the shared AHB slave bus: static priority
// with an aging boost, round-robin tie-break, grant held through bursts.
module ahb_qos_arbiter
  import ahb_arb_pkg::*;
#(
  parameter int unsigned NUM_MASTERS = 4,
  parameter int unsigned PRIO_WIDTH  = 2,
  parameter int unsigned AGE_LIMIT   = 15,
  parameter int unsigned IDX_W       = $clog2(NUM_MASTERS)
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [NUM_MASTERS-1:0]           req,
  input  logic [NUM_MASTERS*PRIO_WIDTH-1:0] master_priority,
  input  logic [1:0]                       htrans_owner,
  input  logic                             hready,
  output logic [NUM_MASTERS-1:0]           grant,
  output logic                             grant_valid,
  output logic [IDX_W-1:0]                 winner,
  output logic                             boosted
);

  localparam int unsigned AGE_W = $clog2(AGE_LIMIT + 1);
  localparam int unsigned EFF_W = PRIO_WIDTH + 1;

  logic [0:0]             state_q, state_d;
  logic [NUM_MASTERS-1:0] grant_q, grant_d;
  logic [IDX_W-1:0]       winner_q, winner_d;
  logic [IDX_W-1:0]       last_q, last_d;
  logic                   boosted_q, boosted_d;
  logic [AGE_W-1:0]       age_q [NUM_MASTERS];
  logic [AGE_W-1:0]       age_d [NUM_MASTERS];

  logic [NUM_MASTERS-1:0] boost;
  logic [NUM_MASTERS-1:0] top_mask;
  logic [EFF_W-1:0]       eff [NUM_MASTERS];
  logic [EFF_W-1:0]       max_eff;
  logic [IDX_W-1:0]       start_ptr;
  logic [IDX_W-1:0]       pick_idx;
  logic                   pick_found;
  logic                   ap;

  assign ap = hready && ((state_q == ARB_IDLE) || htrans_allows_ap(htrans_owner));

  assign start_ptr = (last_q == IDX_W'(NUM_MASTERS - 1)) ? '0 : last_q + IDX_W'(1);

  // Boost sits above the static priority so any aged requester outranks all others.
  always_comb begin
    max_eff = '0;
    for (int unsigned i = 0; i < NUM_MASTERS; i++) begin
      boost[i] = (age_q[i] == AGE_W'(AGE_LIMIT));
      eff[i]   = {boost[i], master_priority[i*PRIO_WIDTH +: PRIO_WIDTH]};
      if (req[i] && (eff[i] > max_eff)) max_eff = eff[i];
    end
    for (int unsigned i = 0; i < NUM_MASTERS; i++) begin
      top_mask[i] = req[i] && (eff[i] == max_eff);
    end
  end

  ahb_rr_pick #(
    .N     (NUM_MASTERS),
    .IDX_W (IDX_W)
  ) u_pick (
    .mask_i  (top_mask),
    .start_i (start_ptr),
    .idx_o   (pick_idx),
    .found_o (pick_found)
  );

  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    winner_d  = winner_q;
    last_d    = last_q;
    boosted_d = 1'b0;
    if (ap) begin
      if (pick_found) begin
        state_d           = ARB_OWNED;
        grant_d           = '0;
        grant_d[pick_idx] = 1'b1;
        winner_d          = pick_idx;
        last_d            = pick_idx;
        boosted_d         = boost[pick_idx];
      end else begin
        state_d = ARB_IDLE;
        grant_d = '0;
      end
    end
  end

  // The master winning on this edge clears too, so a saturated age cannot re-win next turn.
  always_comb begin
    for (int unsigned i = 0; i < NUM_MASTERS; i++) begin
      age_d[i] = '0;
      if (req[i] && !grant_q[i]) begin
        age_d[i] = (age_q[i] == AGE_W'(AGE_LIMIT)) ? age_q[i] : age_q[i] + AGE_W'(1);
      end
      if (ap && pick_found && (pick_idx == IDX_W'(i))) age_d[i] = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ARB_IDLE;
      grant_q   <= '0;
      winner_q  <= '0;
      last_q    <= IDX_W'(NUM_MASTERS - 1);
      boosted_q <= 1'b0;
      for (int unsigned i = 0; i < NUM_MASTERS; i++) age_q[i] <= '0;
    end else begin
      state_q   <= state_d;
      grant_q   <= grant_d;
      winner_q  <= winner_d;
      last_q    <= last_d;
      boosted_q <= boosted_d;
      for (int unsigned i = 0; i < NUM_MASTERS; i++) age_q[i] <= age_d[i];
    end
  end

  assign grant       = grant_q;
  assign grant_valid = (state_q == ARB_OWNED);
  assign winner      = winner_q;
  assign boosted     = boosted_q;

endmodule

// File: tb/tb_ahb_qos_arbiter.sv
// Directed self-checking bench for ahb_qos_arbiter (4 masters, AGE_LIMIT 15).
module tb_ahb_qos_arbiter;
  import ahb_arb_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] req;
  logic [7:0] master_priority;
  logic [1:0] htrans_owner;
  logic       hready;
  logic [3:0] grant;
  logic       grant_valid;
  logic [1:0] winner;
  logic       boosted;

  int unsigned checks = 0;
  int unsigned errors = 0;

  // m3..m0 packed {DMA, NET, CIM, CPU}
  localparam logic [7:0] PRIO_DEFAULT = {PRIO_DMA, PRIO_NET, PRIO_CIM, PRIO_CPU};
  localparam logic [7:0] PRIO_TIE12   = {PRIO_DMA, PRIO_CIM, PRIO_CIM, PRIO_CPU};

  ahb_qos_arbiter #(
    .NUM_MASTERS (4),
    .PRIO_WIDTH  (2),
    .AGE_LIMIT   (15)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .req             (req),
    .master_priority (master_priority),
    .htrans_owner    (htrans_owner),
    .hready          (hready),
    .grant           (grant),
    .grant_valid     (grant_valid),
    .winner          (winner),
    .boosted         (boosted)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    req = '0;
    htrans_owner = HTRANS_IDLE;
    hready = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic expect_state(input string tag, input logic [3:0] g, input logic [1:0] w,
                              input logic b);
    check({tag, ".grant"}, 32'(grant), 32'(g));
    check({tag, ".valid"}, 32'(grant_valid), 32'(|g));
    check({tag, ".winner"}, 32'(winner), 32'(w));
    check({tag, ".boosted"}, 32'(boosted), 32'(b));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    master_priority = PRIO_DEFAULT;
    do_reset();
    expect_state("reset", 4'b0000, 2'd0, 1'b0);

    // Static priority: CPU (m0) beats everyone.
    req = 4'b1111; htrans_owner = HTRANS_NONSEQ; hready = 1'b1;
    tick();
    expect_state("prio", 4'b0001, 2'd0, 1'b0);

    // Round-robin between equal-priority m1 and m2.
    do_reset();
    master_priority = PRIO_TIE12;
    req = 4'b0110; htrans_owner = HTRANS_NONSEQ; hready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      tick();
      expect_state($sformatf("rr%0d", k), (k % 2 == 0) ? 4'b0010 : 4'b0100,
                   (k % 2 == 0) ? 2'd1 : 2'd2, 1'b0);
    end

    // Burst hold: m3 owns through SEQ/BUSY and wait states.
    do_reset();
    master_priority = PRIO_DEFAULT;
    req = 4'b1000; htrans_owner = HTRANS_NONSEQ; hready = 1'b1;
    tick();
    expect_state("burst_own", 4'b1000, 2'd3, 1'b0);
    req = 4'b1001; htrans_owner = HTRANS_SEQ;
    for (int k = 0; k < 4; k++) begin
      hready = (k % 2 == 0);
      tick();
      check($sformatf("burst_seq%0d", k), 32'(grant), 32'(4'b1000));
    end
    htrans_owner = HTRANS_BUSY; hready = 1'b1;
    tick();
    check("burst_busy", 32'(grant), 32'(4'b1000));
    htrans_owner = HTRANS_NONSEQ; hready = 1'b0;
    tick();
    check("burst_wait", 32'(grant), 32'(4'b1000));
    hready = 1'b1;
    tick();
    expect_state("burst_handover", 4'b0001, 2'd0, 1'b0);

    // Starvation: m3 boosted after 15 waiting cycles, twice in a row.
    do_reset();
    req = 4'b1001; htrans_owner = HTRANS_NONSEQ; hready = 1'b1;
    for (int k = 1; k <= 33; k++) begin
      tick();
      if (k == 16 || k == 33)
        expect_state($sformatf("age%0d", k), 4'b1000, 2'd3, 1'b1);
      else
        expect_state($sformatf("age%0d", k), 4'b0001, 2'd0, 1'b0);
    end

    // Park, IDLE-state arbitration, then reset during a held burst.
    do_reset();
    req = 4'b0100; htrans_owner = HTRANS_NONSEQ; hready = 1'b1;
    tick();
    expect_state("park_own", 4'b0100, 2'd2, 1'b0);
    req = 4'b0000; htrans_owner = HTRANS_IDLE;
    tick();
    expect_state("park", 4'b0000, 2'd2, 1'b0);
    req = 4'b0010; htrans_owner = HTRANS_SEQ; hready = 1'b0;
    tick();
    expect_state("idle_nready", 4'b0000, 2'd2, 1'b0);
    hready = 1'b1;
    tick();
    expect_state("idle_seq_ap", 4'b0010, 2'd1, 1'b0);
    req = 4'b0001;
    tick();
    expect_state("seq_hold", 4'b0010, 2'd1, 1'b0);
    rst = 1'b1;
    tick();
    expect_state("rst_mid_burst", 4'b0000, 2'd0, 1'b0);
    rst = 1'b0;
    req = 4'b0000;
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
